// File: rtl/dma_pkg.sv
// Shared DMA constants, channel-id type and the round-robin pick helper
// used by the LINT master arbiters.
package dma_pkg;

  localparam int DMA_CH_NUM   = 4;
  localparam int LINT_ADDR_WD = 32;
  localparam int LINT_DATA_WD = 32;
  localparam int LINT_BE_WD   = LINT_DATA_WD / 8;
  localparam int CH_ID_WD     = $clog2(DMA_CH_NUM);

  typedef logic [CH_ID_WD-1:0] ch_id_t;

  // rr_pick works on a fixed maximum width so any CH_NUM up to 32 can use it
  localparam int RR_MAX_CH = 32;
  localparam int RR_IDX_WD = 5;

  typedef struct packed {
    logic                 found;
    logic [RR_MAX_CH-1:0] onehot;
    logic [RR_IDX_WD-1:0] idx;
  } rr_pick_t;

  // First requester at or above ptr, wrapping modulo n (ptr < n assumed).
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_CH-1:0] req,
                                       input logic [RR_IDX_WD-1:0] ptr,
                                       input logic [RR_IDX_WD:0]   n);
    rr_pick_t             r;
    logic [RR_IDX_WD:0]   c;
    r = '0;
    c = '0;
    // Scan from the farthest offset down so the nearest requester wins last
    for (int i = RR_MAX_CH - 1; i >= 0; i--) begin
      if (i < int'(n)) begin
        c = {1'b0, ptr} + (RR_IDX_WD + 1)'(i);
        if (c >= n) c = c - n;
        if (req[c[RR_IDX_WD-1:0]]) begin
          r.found = 1'b1;
          r.idx   = c[RR_IDX_WD-1:0];
        end
      end
    end
    if (r.found) r.onehot = RR_MAX_CH'(1) << r.idx;
    return r;
  endfunction

endpackage

// File: rtl/lint_id_fifo.sv
// In-order FIFO of channel ids for accepted LINT transactions; a pop and a
// push in the same cycle are both honoured, even when full.
module lint_id_fifo
  import dma_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_WD = CH_ID_WD
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     i_push,
  input  logic [ID_WD-1:0]         i_data,
  input  logic                     i_pop,
  output logic [ID_WD-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [ID_WD-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == CW'(DEPTH));
  assign o_count   = r_cnt;
  assign o_head    = r_mem[r_rd];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= (r_wr == LAST) ? '0 : r_wr + 1'b1;
      if (w_do_pop)  r_rd <= (r_rd == LAST) ? '0 : r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/lint_master_arbiter.sv
// Round-robin arbiter sharing one LINT master port among CH_NUM channels,
// with request lock while stalled and in-order response routing.
module lint_master_arbiter
  import dma_pkg::*;
#(
  parameter int CH_NUM          = DMA_CH_NUM,
  parameter int ADDR_WD         = LINT_ADDR_WD,
  parameter int DATA_WD         = LINT_DATA_WD,
  parameter int BE_WD           = DATA_WD / 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CH_ID_WD        = $clog2(CH_NUM)
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [CH_NUM-1:0]             ch_req_i,
  input  logic [CH_NUM-1:0]             ch_we_i,
  input  logic [CH_NUM*BE_WD-1:0]       ch_be_i,
  input  logic [CH_NUM*DATA_WD-1:0]     ch_wdata_i,
  input  logic [CH_NUM*ADDR_WD-1:0]     ch_addr_i,
  output logic [CH_NUM-1:0]             ch_gnt_o,
  output logic [CH_NUM-1:0]             ch_rvalid_o,
  output logic [DATA_WD-1:0]            ch_rdata_o,
  output logic                          m_req_o,
  output logic                          m_we_o,
  output logic [BE_WD-1:0]              m_be_o,
  output logic [DATA_WD-1:0]            m_wdata_o,
  output logic [ADDR_WD-1:0]            m_addr_o,
  input  logic                          m_gnt_i,
  input  logic                          m_rvalid_i,
  input  logic [DATA_WD-1:0]            m_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
  output logic                          err_o
);

  localparam logic [CH_ID_WD-1:0] LAST_CH = CH_ID_WD'(CH_NUM - 1);

  logic [CH_ID_WD-1:0] r_ptr;
  logic [CH_ID_WD-1:0] r_lock_id;
  logic                r_lock;
  logic                r_err;
  logic [CH_ID_WD-1:0] w_sel;
  logic [CH_ID_WD-1:0] w_head;
  logic                w_lock_hit;
  logic                w_sel_valid;
  logic                w_accept;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  rr_pick_t            w_rr;

  assign w_lock_hit  = r_lock & ch_req_i[r_lock_id];
  assign w_rr        = rr_pick(RR_MAX_CH'(ch_req_i), RR_IDX_WD'(r_ptr),
                               (RR_IDX_WD + 1)'(CH_NUM));
  assign w_sel       = w_lock_hit ? r_lock_id : w_rr.idx[CH_ID_WD-1:0];
  // A full id FIFO masks every channel, including a locked one
  assign w_sel_valid = (w_lock_hit | w_rr.found) & ~w_full;
  assign w_accept    = m_req_o & m_gnt_i;
  assign w_pop       = m_rvalid_i & ~w_empty;
  assign ch_rdata_o  = m_rdata_i;
  assign err_o       = r_err;

  always_comb begin
    m_req_o   = w_sel_valid;
    m_we_o    = 1'b0;
    m_be_o    = '0;
    m_wdata_o = '0;
    m_addr_o  = '0;
    ch_gnt_o  = '0;
    if (w_sel_valid) begin
      m_we_o          = ch_we_i[w_sel];
      m_be_o          = ch_be_i[w_sel*BE_WD +: BE_WD];
      m_wdata_o       = ch_wdata_i[w_sel*DATA_WD +: DATA_WD];
      m_addr_o        = ch_addr_i[w_sel*ADDR_WD +: ADDR_WD];
      ch_gnt_o[w_sel] = m_gnt_i;
    end
  end

  always_comb begin
    ch_rvalid_o = '0;
    if (w_pop) ch_rvalid_o[w_head] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ptr     <= '0;
      r_lock    <= 1'b0;
      r_lock_id <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= m_rvalid_i & w_empty;
      if (w_accept) begin
        r_lock <= 1'b0;
        r_ptr  <= (w_sel == LAST_CH) ? '0 : w_sel + 1'b1;
      end else if (m_req_o) begin
        // Stalled request must stay on the bus until granted
        r_lock    <= 1'b1;
        r_lock_id <= w_sel;
      end else if (r_lock & ~ch_req_i[r_lock_id]) begin
        r_lock <= 1'b0;
      end
    end
  end

  lint_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .ID_WD (CH_ID_WD)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .i_push  (w_accept),
    .i_data  (w_sel),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (outstanding_o)
  );

endmodule

// File: tb/tb_lint_master_arbiter.sv
// Directed bench for lint_master_arbiter: grant and response expectations are
// queued by the drivers and consumed by a negedge monitor.
module tb_lint_master_arbiter;

  localparam int CH = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int MO = 4;

  logic            clk_i = 1'b0;
  logic            rstn_i;
  logic [CH-1:0]   ch_req_i;
  logic [CH-1:0]   ch_we_i;
  logic [CH*BW-1:0] ch_be_i;
  logic [CH*DW-1:0] ch_wdata_i;
  logic [CH*AW-1:0] ch_addr_i;
  logic [CH-1:0]   ch_gnt_o;
  logic [CH-1:0]   ch_rvalid_o;
  logic [DW-1:0]   ch_rdata_o;
  logic            m_req_o;
  logic            m_we_o;
  logic [BW-1:0]   m_be_o;
  logic [DW-1:0]   m_wdata_o;
  logic [AW-1:0]   m_addr_o;
  logic            m_gnt_i;
  logic            m_rvalid_i;
  logic [DW-1:0]   m_rdata_i;
  logic [2:0]      outstanding_o;
  logic            err_o;

  // grant entry {ch_gnt, we, addr}; response entry {ch_rvalid, rdata}
  logic [36:0] exp_g_q[$];
  logic [35:0] exp_r_q[$];
  int n_total = 0;
  int n_bad   = 0;

  lint_master_arbiter #(
    .CH_NUM(CH), .ADDR_WD(AW), .DATA_WD(DW), .BE_WD(BW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .ch_req_i(ch_req_i), .ch_we_i(ch_we_i), .ch_be_i(ch_be_i),
    .ch_wdata_i(ch_wdata_i), .ch_addr_i(ch_addr_i),
    .ch_gnt_o(ch_gnt_o), .ch_rvalid_o(ch_rvalid_o), .ch_rdata_o(ch_rdata_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_be_o(m_be_o),
    .m_wdata_o(m_wdata_o), .m_addr_o(m_addr_o),
    .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk_i);
  endtask

  task automatic clear_in();
    ch_req_i   = '0;
    ch_we_i    = '0;
    ch_be_i    = '0;
    ch_wdata_i = '0;
    ch_addr_i  = '0;
    m_gnt_i    = 1'b0;
  endtask

  task automatic set_ch(input int c, input logic [31:0] a, input logic we, input logic [31:0] wd);
    ch_req_i[c]             = 1'b1;
    ch_we_i[c]              = we;
    ch_be_i[c*BW +: BW]     = 4'hF;
    ch_wdata_i[c*DW +: DW]  = wd;
    ch_addr_i[c*AW +: AW]   = a;
  endtask

  task automatic exp_gnt(input int c, input logic we, input logic [31:0] a);
    exp_g_q.push_back({4'(1 << c), we, a});
  endtask

  task automatic respond(input logic [31:0] d, input logic [3:0] onehot);
    m_rvalid_i = 1'b1;
    m_rdata_i  = d;
    exp_r_q.push_back({onehot, d});
  endtask

  task automatic do_reset();
    rstn_i     = 1'b0;
    m_rvalid_i = 1'b0;
    clear_in();
    #1;
    chk("reset_outstanding", 64'(outstanding_o), 64'd0);
    cyc();
    cyc();
    rstn_i = 1'b1;
  endtask

  // scoreboard monitor
  always @(negedge clk_i) begin
    logic [36:0] eg;
    logic [35:0] er;
    if (rstn_i) begin
      if (ch_gnt_o != '0 || (m_req_o && m_gnt_i)) begin
        if (exp_g_q.size() == 0) chk("gnt_unexpected", 64'({ch_gnt_o, m_we_o, m_addr_o}), 64'd0);
        else begin
          eg = exp_g_q.pop_front();
          chk("gnt", 64'({ch_gnt_o, m_we_o, m_addr_o}), 64'(eg));
        end
      end
      if (m_rvalid_i) begin
        if (exp_r_q.size() == 0) chk("rsp_unexpected", 64'({ch_rvalid_o, ch_rdata_o}), 64'd0);
        else begin
          er = exp_r_q.pop_front();
          chk("rsp", 64'({ch_rvalid_o, ch_rdata_o}), 64'(er));
        end
      end
    end
  end

  initial begin
    int seq[5] = '{0, 1, 2, 3, 0};
    rstn_i     = 1'b0;
    m_rvalid_i = 1'b0;
    m_rdata_i  = '0;
    clear_in();
    #1;
    chk("rst_outstanding", 64'(outstanding_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_idle_bus", 64'({m_req_o, m_we_o, m_be_o, m_addr_o}), 64'd0);
    chk("rst_gnt", 64'(ch_gnt_o), 64'd0);
    cyc();
    rstn_i = 1'b1;

    // single read on ch2
    set_ch(2, 32'h100, 1'b0, 32'h0);
    m_gnt_i = 1'b1;
    exp_gnt(2, 1'b0, 32'h100);
    at_neg();
    chk("t1_out_before", 64'(outstanding_o), 64'd0);
    cyc();
    clear_in();
    at_neg();
    chk("t1_out_after_accept", 64'(outstanding_o), 64'd1);
    cyc();
    respond(32'hDEADBEEF, 4'b0100);
    cyc();
    m_rvalid_i = 1'b0;
    at_neg();
    chk("t1_out_after_rsp", 64'(outstanding_o), 64'd0);

    // round-robin with all channels requesting
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (k < 5) begin
        for (int c = 0; c < CH; c++) set_ch(c, 32'h1000 + 32'(c * 16), 1'b0, 32'h0);
        m_gnt_i = 1'b1;
        exp_gnt(seq[k], 1'b0, 32'h1000 + 32'(seq[k] * 16));
      end else begin
        clear_in();
      end
      if (k >= 1) respond(32'hA0 + 32'(k), 4'(1 << seq[k-1]));
      else m_rvalid_i = 1'b0;
      cyc();
    end
    m_rvalid_i = 1'b0;
    at_neg();
    chk("t2_out_drained", 64'(outstanding_o), 64'd0);

    // stall and lock on ch1 while ch0 joins
    do_reset();
    set_ch(1, 32'h2010, 1'b1, 32'h55AA);
    at_neg();
    chk("t3_addr_c0", 64'(m_addr_o), 64'h2010);
    cyc();
    set_ch(0, 32'h2000, 1'b0, 32'h0);
    at_neg();
    chk("t3_addr_c1", 64'(m_addr_o), 64'h2010);
    cyc();
    at_neg();
    chk("t3_addr_c2", 64'(m_addr_o), 64'h2010);
    chk("t3_wdata_we", 64'({m_we_o, m_be_o, m_wdata_o}), 64'h1_F_0000_55AA);
    cyc();
    m_gnt_i = 1'b1;
    exp_gnt(1, 1'b1, 32'h2010);
    cyc();
    ch_req_i[1] = 1'b0;
    exp_gnt(0, 1'b0, 32'h2000);
    cyc();
    clear_in();
    respond(32'h1111, 4'b0010);
    cyc();
    respond(32'h2222, 4'b0001);
    cyc();
    m_rvalid_i = 1'b0;

    // outstanding limit
    do_reset();
    set_ch(0, 32'h3000, 1'b0, 32'h0);
    m_gnt_i = 1'b1;
    for (int i = 0; i < MO; i++) begin
      exp_gnt(0, 1'b0, 32'h3000);
      cyc();
    end
    at_neg();
    chk("t4_masked_req", 64'(m_req_o), 64'd0);
    chk("t4_full_count", 64'(outstanding_o), 64'd4);
    cyc();
    respond(32'h44, 4'b0001);
    at_neg();
    chk("t4_masked_same_cycle_rvalid", 64'({m_req_o, ch_gnt_o}), 64'd0);
    cyc();
    m_rvalid_i = 1'b0;
    exp_gnt(0, 1'b0, 32'h3000);
    at_neg();
    chk("t4_unmasked_req", 64'(m_req_o), 64'd1);
    chk("t4_count_after_pop", 64'(outstanding_o), 64'd3);
    cyc();
    clear_in();
    for (int i = 0; i < MO; i++) begin
      respond(32'h50 + 32'(i), 4'b0001);
      cyc();
    end
    m_rvalid_i = 1'b0;
    at_neg();
    chk("t4_out_drained", 64'(outstanding_o), 64'd0);

    // spurious response
    cyc();
    respond(32'hBAD, 4'b0000);
    at_neg();
    chk("t5_err_not_yet", 64'(err_o), 64'd0);
    cyc();
    m_rvalid_i = 1'b0;
    at_neg();
    chk("t5_err_pulse", 64'(err_o), 64'd1);
    chk("t5_out_zero", 64'(outstanding_o), 64'd0);
    cyc();
    at_neg();
    chk("t5_err_cleared", 64'(err_o), 64'd0);

    // reset with transactions in flight and a lock held
    do_reset();
    set_ch(1, 32'h4010, 1'b0, 32'h0);
    m_gnt_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_gnt(1, 1'b0, 32'h4010);
      cyc();
    end
    ch_req_i[1] = 1'b0;
    set_ch(2, 32'h4020, 1'b0, 32'h0);
    m_gnt_i = 1'b0;
    at_neg();
    chk("t6_out_before_reset", 64'(outstanding_o), 64'd3);
    cyc();
    do_reset();
    respond(32'h1A7E, 4'b0000);
    cyc();
    m_rvalid_i = 1'b0;
    at_neg();
    chk("t6_late_rvalid_err", 64'(err_o), 64'd1);
    chk("t6_out_after_reset", 64'(outstanding_o), 64'd0);
    cyc();
    set_ch(3, 32'h4030, 1'b0, 32'h0);
    set_ch(0, 32'h4040, 1'b0, 32'h0);
    m_gnt_i = 1'b1;
    exp_gnt(0, 1'b0, 32'h4040);
    cyc();
    exp_gnt(3, 1'b0, 32'h4030);
    cyc();
    clear_in();
    respond(32'hC0, 4'b0001);
    cyc();
    respond(32'hC3, 4'b1000);
    cyc();
    m_rvalid_i = 1'b0;
    at_neg();
    chk("t6_out_drained", 64'(outstanding_o), 64'd0);

    chk("gnt_queue_left", 64'(exp_g_q.size()), 64'd0);
    chk("rsp_queue_left", 64'(exp_r_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/lint_master_arbiter.md
Name: lint_master_arbiter

Overview:
- Shares one LINT master port (src-read or dst-write side of the DMA) among CH_NUM channel requesters.
- Replaces the forbid/sel_q scheme in the DMA top with a proper pipelined arbiter:
  - round-robin selection with a request lock;
  - in-order tracking of up to MAX_OUTSTANDING accepted transactions;
  - rvalid/rdata routed back to the originating channel.
- Instantiated twice in the DMA top: once for the src side, once for the dst side.

Parameters:
- CH_NUM, 4: number of requesting channels (≥2).
- ADDR_WD, 32: LINT address width.
- DATA_WD, 32: LINT data width.
- BE_WD, DATA_WD/8: byte-enable width.
- MAX_OUTSTANDING, 4: accepted-but-unanswered transactions allowed (power of 2, ≥1).
- CH_ID_WD, $clog2(CH_NUM): channel index width.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- ch_req_i  in  CH_NUM  per-channel LINT request
- ch_we_i  in  CH_NUM  per-channel write enable
- ch_be_i  in  CH_NUM*BE_WD  flattened byte enables; channel c at [c*BE_WD +: BE_WD]
- ch_wdata_i  in  CH_NUM*DATA_WD  flattened write data
- ch_addr_i  in  CH_NUM*ADDR_WD  flattened addresses
- ch_gnt_o  out  CH_NUM  one-hot grant back to channels
- ch_rvalid_o  out  CH_NUM  one-hot response valid back to channels
- ch_rdata_o  out  DATA_WD  response data, broadcast to all channels
- m_req_o  out  1  master LINT request
- m_we_o  out  1  master write enable
- m_be_o  out  BE_WD  master byte enables
- m_wdata_o  out  DATA_WD  master write data
- m_addr_o  out  ADDR_WD  master address
- m_gnt_i  in  1  master grant
- m_rvalid_i  in  1  master response valid (in order, one per accepted request)
- m_rdata_i  in  DATA_WD  master response data
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  current outstanding count
- err_o  out  1  one-cycle pulse: m_rvalid_i received with nothing outstanding

Behaviour:
- Clock is clk_i; reset is rstn_i, asynchronous, active-low.
- Reset state:
  - priority pointer = 0 (ch0 highest priority);
  - lock clear;
  - ID FIFO empty; outstanding_o = 0;
  - err_o = 0.
- All request-path outputs are combinational from inputs and state. With no requests: m_req_o = 0, m_we_o = 0, m_be_o/m_wdata_o/m_addr_o = 0.
- Selection:
  - If lock is set and ch_req_i[lock_id] = 1, select lock_id.
  - Otherwise select the first requesting channel starting at the pointer and wrapping upward modulo CH_NUM.
- Full mask:
  - When outstanding_o == MAX_OUTSTANDING, no channel is selected: m_req_o = 0 and ch_gnt_o = 0.
  - A simultaneous m_rvalid_i does not unmask that cycle.
- Forwarding: the selected channel's req/we/be/wdata/addr drive m_*_o.
- Grant: ch_gnt_o[sel] = m_gnt_i (zero latency); all other grant bits are 0.
- Accept: an accept is m_req_o & m_gnt_i. On accept:
  - push sel into the ID FIFO;
  - pointer <= sel+1 (wrapping to 0 after CH_NUM-1);
  - lock clears.
- Lock:
  - If m_req_o & ~m_gnt_i: lock <= 1, lock_id <= sel. The selection is held until granted (LINT stability rule).
  - If the locked channel drops its req, lock clears that cycle and normal round-robin resumes.
- Response routing, same cycle as m_rvalid_i:
  - ch_rvalid_o[fifo_head] = m_rvalid_i;
  - ch_rdata_o = m_rdata_i;
  - pop the FIFO.
- Outstanding count: push and pop in the same cycle leave the count unchanged; push only adds 1; pop only subtracts 1.
- m_rvalid_i while the FIFO is empty:
  - ch_rvalid_o = 0;
  - no pop;
  - err_o pulses high for 1 cycle, registered (asserted the cycle after).
- Writes and reads are both tracked; LINT returns rvalid for writes too.
- Reset mid-operation: all state clears immediately. Responses pending at reset are lost; a late m_rvalid_i after reset raises err_o.

Decomposition:
- dma_pkg:
  - CH_NUM default, LINT width constants;
  - typedef ch_id_t (CH_ID_WD bits);
  - function rr_pick(req, ptr) returning a one-hot pick and index.
- Sub-module lint_id_fifo:
  - synchronous FIFO of ch_id_t, depth MAX_OUTSTANDING;
  - push/pop/full/empty/count;
  - pop-before-push allowed in the same cycle.

Test Plan:
- Single read: ch2 req, addr 0x100, m_gnt_i same cycle, m_rvalid_i two cycles later with rdata 0xDEADBEEF → ch_gnt_o = 4'b0100 at accept; ch_rvalid_o = 4'b0100 with ch_rdata_o = 0xDEADBEEF; outstanding_o goes 0→1→0.
- Round-robin: all 4 channels hold req, m_gnt_i = 1 every cycle → grants in order ch0, ch1, ch2, ch3, ch0; rvalids returned in order map to the same channel sequence.
- Stall/lock: ch1 req, m_gnt_i = 0 for 3 cycles while ch0 also raises req → m_addr_o stays ch1's address for all 3 cycles; ch1 granted first, ch0 next.
- Outstanding limit: MAX_OUTSTANDING = 2, m_gnt_i = 1, m_rvalid_i = 0 → two accepts, then m_req_o = 0 with outstanding_o = 2. One m_rvalid_i → the next cycle an accept occurs again.
- Spurious response: m_rvalid_i with an empty FIFO → ch_rvalid_o = 0; err_o = 1 for exactly one cycle; outstanding_o stays 0.
- Reset mid-flight: 3 outstanding, assert rstn_i low → outstanding_o = 0, pointer 0, lock clear. After release, ch3 and ch0 request → ch0 granted first.
